// File: rtl/ex_nor3_pkg.sv
// Shared defaults and the per-bit XNOR3 helper for the ex_nor3 block.
package ex_nor3_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 16;

  function automatic logic xnor3(input logic a, input logic b, input logic c);
    return ~(a ^ b ^ c);
  endfunction

endpackage

// File: rtl/ex_nor3_xnor3_cell.sv
// One-bit combinational slice of the 3-input XNOR; the top replicates it per lane.
module xnor3_cell
  import ex_nor3_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic o
);

  assign o = xnor3(a, b, c);

endmodule

// File: rtl/ex_nor3.sv
// Bitwise 3-input XNOR with valid qualifier and a saturating all-ones match counter.
// Optional feature: define EX_NOR3_REG_EN to register o/out_valid (1-cycle latency).
module ex_nor3
  import ex_nor3_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] o,
  output logic             out_valid,
  output logic [CNT_W-1:0] match_cnt,
  input  logic             clr_cnt
);

  logic [WIDTH-1:0] w_res;
  logic             w_match;
  logic             w_sat;
  logic [CNT_W-1:0] r_cnt;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    xnor3_cell u_cell (
      .a (a[g]),
      .b (b[g]),
      .c (c[g]),
      .o (w_res[g])
    );
  end

  assign w_match = in_valid & (&w_res);
  assign w_sat   = (r_cnt == {CNT_W{1'b1}});

  // clear wins over a same-cycle match; saturate instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_match && !w_sat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign match_cnt = r_cnt;

`ifdef EX_NOR3_REG_EN
  logic [WIDTH-1:0] r_o;
  logic             r_out_valid;

  // o keeps the last accepted result while out_valid pulses per accepted sample
  always_ff @(posedge clk) begin
    if (rst) begin
      r_o         <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      r_o         <= w_res;
      r_out_valid <= 1'b1;
    end else begin
      r_o         <= r_o;
      r_out_valid <= 1'b0;
    end
  end

  assign o         = r_o;
  assign out_valid = r_out_valid;
`else
  assign o         = w_res;
  assign out_valid = in_valid;
`endif

endmodule

// File: tb/tb_ex_nor3.sv
// Scoreboard bench for ex_nor3 (WIDTH=4, CNT_W=2); works with or without EX_NOR3_REG_EN.
module tb_ex_nor3;

  typedef struct packed {
    logic [3:0] o;
    logic       ov;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;
  logic [3:0] o;
  logic       out_valid;
  logic [1:0] match_cnt;
  logic       clr_cnt;

  exp_t       sb[$];
  exp_t       ex;
  logic [7:0] tt;
  logic [1:0] m_cnt;
  logic [3:0] m_hold;
  int         checks;
  int         errors;

  ex_nor3 #(.WIDTH(4), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .o         (o),
    .out_valid (out_valid),
    .match_cnt (match_cnt),
    .clr_cnt   (clr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus at negedge, push expected output, advance count model.
  task automatic drive(input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] tc,
                       input logic v, input logic cl, input logic rs);
    logic [3:0] e;
    exp_t       x;
    @(negedge clk);
    a = ta; b = tb; c = tc; in_valid = v; clr_cnt = cl; rst = rs;
    for (int k = 0; k < 4; k++) e[k] = tt[{ta[k], tb[k], tc[k]}];
`ifdef EX_NOR3_REG_EN
    if (rs) begin
      m_hold = 4'h0; x.o = 4'h0; x.ov = 1'b0;
    end else if (v) begin
      m_hold = e; x.o = e; x.ov = 1'b1;
    end else begin
      x.o = m_hold; x.ov = 1'b0;
    end
`else
    x.o = e; x.ov = v;
`endif
    sb.push_back(x);
    if (rs || cl) m_cnt = 2'd0;
    else if (v && e == 4'hF && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
  endtask

  task automatic wait_out();
`ifdef EX_NOR3_REG_EN
    @(posedge clk); #1;
`else
    #2;
`endif
  endtask

  task automatic wait_cnt();
`ifndef EX_NOR3_REG_EN
    @(posedge clk); #1;
`endif
  endtask

  task automatic pop_exp();
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got size 0, required >0");
      ex = '0;
    end else begin
      ex = sb.pop_front();
    end
  endtask

  task automatic test_reset();
    drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    wait_out();
    pop_exp();
    checks++;
    if (o !== ex.o) begin errors++; $display("FAIL reset_o: got %b, required %b", o, ex.o); end
    checks++;
    if (out_valid !== ex.ov) begin errors++; $display("FAIL reset_ov: got %b, required %b", out_valid, ex.ov); end
    wait_cnt();
    checks++;
    if (match_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d, required 0", match_cnt); end
  endtask

  task automatic test_truth_table();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] s;
      s = 3'(i);
      drive({4{s[2]}}, {4{s[1]}}, {4{s[0]}}, 1'b1, 1'b0, 1'b0);
      wait_out();
      pop_exp();
      checks++;
      if (o !== ex.o) begin errors++; $display("FAIL truth_o[%0d]: got %b, required %b", i, o, ex.o); end
      checks++;
      if (out_valid !== ex.ov) begin errors++; $display("FAIL truth_ov[%0d]: got %b, required %b", i, out_valid, ex.ov); end
      wait_cnt();
      checks++;
      if (match_cnt !== m_cnt) begin errors++; $display("FAIL truth_cnt[%0d]: got %0d, required %0d", i, match_cnt, m_cnt); end
    end
  endtask

  task automatic test_lanes();
    logic [3:0] want[2];
    logic [3:0] cv[2];
    want[0] = 4'b1001; want[1] = 4'b0110;
    cv[0] = 4'b0000;   cv[1] = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      drive(4'b0011, 4'b0101, cv[i], 1'b1, 1'b0, 1'b0);
      wait_out();
      pop_exp();
      checks++;
      if (o !== want[i]) begin errors++; $display("FAIL lanes_o[%0d]: got %b, required %b", i, o, want[i]); end
      checks++;
      if (o !== ex.o) begin errors++; $display("FAIL lanes_sb[%0d]: got %b, required %b", i, o, ex.o); end
      wait_cnt();
    end
  endtask

  task automatic test_hold();
    drive(4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
    wait_out();
    pop_exp();
    checks++;
    if (o !== 4'hF || out_valid !== 1'b1) begin
      errors++; $display("FAIL hold_accept: got o=%b ov=%b, required o=1111 ov=1", o, out_valid);
    end
    wait_cnt();
    drive(4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    wait_out();
    pop_exp();
    checks++;
    if (o !== ex.o) begin errors++; $display("FAIL hold_o: got %b, required %b", o, ex.o); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_ov: got %b, required 0", out_valid); end
    wait_cnt();
    checks++;
    if (match_cnt !== m_cnt) begin errors++; $display("FAIL hold_cnt: got %0d, required %0d", match_cnt, m_cnt); end
  endtask

  task automatic test_saturation();
    logic [1:0] want[5];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3; want[4] = 2'd3;
    drive(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    wait_out(); pop_exp(); wait_cnt();
    checks++;
    if (match_cnt !== 2'd0) begin errors++; $display("FAIL sat_clr: got %0d, required 0", match_cnt); end
    for (int i = 0; i < 5; i++) begin
      drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      wait_out(); pop_exp(); wait_cnt();
      checks++;
      if (match_cnt !== want[i]) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d, required %0d", i, match_cnt, want[i]); end
    end
  endtask

  task automatic test_clear();
    drive(4'hF, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0);
    wait_out(); pop_exp(); wait_cnt();
    checks++;
    if (match_cnt !== 2'd0) begin errors++; $display("FAIL clear_cnt: got %0d, required 0", match_cnt); end
    drive(4'hF, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
    wait_out(); pop_exp(); wait_cnt();
    checks++;
    if (match_cnt !== 2'd1) begin errors++; $display("FAIL clear_recount: got %0d, required 1", match_cnt); end
  endtask

  task automatic test_rst_midstream();
    drive(4'h0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1);
    wait_out();
    pop_exp();
    checks++;
    if (o !== ex.o) begin errors++; $display("FAIL rstmid_o: got %b, required %b", o, ex.o); end
    checks++;
    if (out_valid !== ex.ov) begin errors++; $display("FAIL rstmid_ov: got %b, required %b", out_valid, ex.ov); end
    wait_cnt();
    checks++;
    if (match_cnt !== 2'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d, required 0", match_cnt); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      logic [3:0] ra, rb, rc;
      logic       rv, rcl;
      ra = 4'($urandom_range(15));
      rb = 4'($urandom_range(15));
      rc = 4'($urandom_range(15));
      if ($urandom_range(2) == 0) rc = ~(ra ^ rb) ^ 4'hF ^ 4'hF;
      rv  = ($urandom_range(3) != 0);
      rcl = ($urandom_range(15) == 0);
      drive(ra, rb, rc, rv, rcl, 1'b0);
      wait_out();
      pop_exp();
      checks++;
      if (o !== ex.o || out_valid !== ex.ov) begin
        errors++; $display("FAIL b2b_out[%0d]: got o=%b ov=%b, required o=%b ov=%b", i, o, out_valid, ex.o, ex.ov);
      end
      wait_cnt();
      checks++;
      if (match_cnt !== m_cnt) begin errors++; $display("FAIL b2b_cnt[%0d]: got %0d, required %0d", i, match_cnt, m_cnt); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, required finish");
    $fatal(1);
  end

  initial begin
    tt = 8'b0110_1001;
    checks = 0; errors = 0;
    m_cnt = 2'd0; m_hold = 4'h0;
    rst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0;
    a = 4'h0; b = 4'h0; c = 4'h0;
    test_reset();
    test_truth_table();
    test_lanes();
    test_hold();
    test_saturation();
    test_clear();
    test_rst_midstream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
